// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode field layout and
// instruction-length defaults used by the fetch stage.
package cpu_pkg;

    localparam int unsigned AW_DEF     = 8;
    localparam int unsigned OPC_HI_MSB = 7;
    localparam int unsigned OPC_HI_LSB = 4;

    localparam logic [15:0] IMM_OPC_MASK_DEF = 16'h1000;
    localparam logic [7:0]  OPC_NOP          = 8'h00;

    typedef enum logic [1:0] {
        ADDR_OP  = 2'd0,
        DATA_OP  = 2'd1,
        DATA_IMM = 2'd2
    } fetch_state_e;

    // An opcode is two bytes long when its high nibble is flagged in the mask.
    function automatic logic opc_is_two_byte(input logic [15:0] mask, input logic [7:0] opc);
        return mask[opc[OPC_HI_MSB:OPC_HI_LSB]];
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: clear (valid only) > hold > load > bubble.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          hold_i,
    input  logic          load_i,
    input  logic [AW-1:0] pc_i,
    input  logic [7:0]    opc_i,
    input  logic [7:0]    imm_i,
    input  logic          two_i,
    output logic          valid_o,
    output logic [AW-1:0] pc_o,
    output logic [7:0]    opc_o,
    output logic [7:0]    imm_o,
    output logic          two_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    opc_q, opc_d;
    logic [7:0]    imm_q, imm_d;
    logic          two_q, two_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        imm_d   = imm_q;
        two_d   = two_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (hold_i) begin
            valid_d = valid_q;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            opc_d   = opc_i;
            imm_d   = imm_i;
            two_d   = two_i;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            opc_q   <= OPC_NOP;
            imm_q   <= 8'h00;
            two_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            imm_q   <= imm_d;
            two_q   <= two_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign opc_o   = opc_q;
    assign imm_o   = imm_q;
    assign two_o   = two_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: walks a byte-wide synchronous memory, assembles 1/2-byte
// instructions into IF/ID and drives the PC register's en/imm controls.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] IMM_OPC_MASK = IMM_OPC_MASK_DEF,
    parameter int unsigned AW           = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [7:0]    imem_rdata_i,
    output logic          pc_en_o,
    output logic          pc_imm_o,
    output logic          ifid_valid_o,
    output logic [AW-1:0] ifid_pc_o,
    output logic [7:0]    ifid_opcode_o,
    output logic [7:0]    ifid_imm_o,
    output logic          ifid_two_byte_o
);

    fetch_state_e  state_q, state_d;
    logic [7:0]    opc_q, opc_d;
    logic [AW-1:0] imem_addr;
    logic          pc_en, pc_imm;
    logic          issue, iss_two;
    logic [7:0]    iss_opc, iss_imm;
    logic          two;

    assign two = opc_is_two_byte(IMM_OPC_MASK, imem_rdata_i);

    // Next state, memory address, PC controls and issue payload.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        imem_addr = pc_i;
        pc_en     = 1'b0;
        pc_imm    = 1'b0;
        issue     = 1'b0;
        iss_opc   = OPC_NOP;
        iss_imm   = 8'h00;
        iss_two   = 1'b0;
        case (state_q)
            ADDR_OP: begin
                state_d = DATA_OP;
            end
            DATA_OP: begin
                if (!stall_i) begin
                    imem_addr = pc_i + AW'(1);
                    if (two) begin
                        opc_d   = imem_rdata_i;
                        state_d = DATA_IMM;
                    end else begin
                        issue   = 1'b1;
                        pc_en   = 1'b1;
                        iss_opc = imem_rdata_i;
                    end
                end
            end
            DATA_IMM: begin
                imem_addr = pc_i + AW'(1);
                if (!stall_i) begin
                    imem_addr = pc_i + AW'(2);
                    issue     = 1'b1;
                    pc_en     = 1'b1;
                    pc_imm    = 1'b1;
                    iss_opc   = opc_q;
                    iss_imm   = imem_rdata_i;
                    iss_two   = 1'b1;
                    state_d   = DATA_OP;
                end
            end
            default: begin
                state_d = ADDR_OP;
            end
        endcase
        // A taken branch wins over everything: PC loads its target, fetch restarts.
        if (flush_i) begin
            pc_en   = 1'b1;
            pc_imm  = 1'b0;
            issue   = 1'b0;
            state_d = ADDR_OP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ADDR_OP;
            opc_q   <= OPC_NOP;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    assign imem_addr_o = imem_addr;
    assign pc_en_o     = pc_en;
    assign pc_imm_o    = pc_imm;

    ifid_reg #(.AW(AW)) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .hold_i  (stall_i),
        .load_i  (issue),
        .pc_i    (pc_i),
        .opc_i   (iss_opc),
        .imm_i   (iss_imm),
        .two_i   (iss_two),
        .valid_o (ifid_valid_o),
        .pc_o    (ifid_pc_o),
        .opc_o   (ifid_opcode_o),
        .imm_o   (ifid_imm_o),
        .two_o   (ifid_two_byte_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed per-cycle vector tables, an async-reset
// sequence and a random run scored against a program-walk model.
module tb_fetch_stage;

    localparam logic [15:0] MASK = 16'h1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] pc;
    logic [7:0] rdata = 8'h00;
    logic [7:0] addr;
    logic       pc_en, pc_imm;
    logic       v, two;
    logic [7:0] ipc, iopc, iimm;

    logic [7:0] mem [256];
    logic [7:0] reset_pc = 8'h00;

    int checks = 0;
    int failures = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc),
        .stall_i         (stall),
        .flush_i         (flush),
        .imem_addr_o     (addr),
        .imem_rdata_i    (rdata),
        .pc_en_o         (pc_en),
        .pc_imm_o        (pc_imm),
        .ifid_valid_o    (v),
        .ifid_pc_o       (ipc),
        .ifid_opcode_o   (iopc),
        .ifid_imm_o      (iimm),
        .ifid_two_byte_o (two)
    );

    always #5 clk = ~clk;

    // Environment: synchronous instruction memory and the PC register.
    always @(posedge clk) rdata <= mem[addr];

    always @(posedge clk or posedge rst) begin
        if (rst)         pc <= reset_pc;
        else if (pc_en)  pc <= flush ? target : (pc + (pc_imm ? 8'd2 : 8'd1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_two(input logic [7:0] opc);
        logic [15:0] m;
        m = MASK;
        return m[opc[7:4]];
    endfunction

    typedef struct {
        int         sc;
        bit         st, fl;
        logic [7:0] tg;
        bit         ca;
        logic [7:0] ad;
        bit         en, im, ev;
        logic [7:0] ep, eo, ei;
        bit         et;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int sc, bit st, bit fl, logic [7:0] tg, bit ca, logic [7:0] ad,
                                bit en, bit im, bit ev, logic [7:0] ep, logic [7:0] eo,
                                logic [7:0] ei, bit et);
        vec_t r;
        r.sc = sc; r.st = st; r.fl = fl; r.tg = tg; r.ca = ca; r.ad = ad;
        r.en = en; r.im = im; r.ev = ev; r.ep = ep; r.eo = eo; r.ei = ei; r.et = et;
        return r;
    endfunction

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        #1;
        if (check) begin
            chk("rst_ifid", {31'b0, v} | {ipc, iopc, iimm, 7'b0, two}, 32'h0);
            chk("rst_pc_en", {31'b0, pc_en}, 32'h0);
            chk("rst_addr", {24'b0, addr}, {24'b0, reset_pc});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_scen(input int s);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset_pc = 8'h00;
        case (s)
            0: begin mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40; end
            1: begin mem[0] = 8'h10; mem[1] = 8'hC5; mem[2] = 8'h7E; mem[3] = 8'h11; end
            2: begin
                mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
                mem[4] = 8'hC5; mem[5] = 8'h7E; mem[8'h40] = 8'h55;
            end
            3: begin mem[8'hFF] = 8'hC0; mem[0] = 8'hAA; mem[1] = 8'h33; reset_pc = 8'hFF; end
            default: begin mem[0] = 8'hC5; mem[1] = 8'h7E; mem[2] = 8'h11; mem[3] = 8'h22; end
        endcase
        do_reset(1'b1);
    endtask

    initial begin
        int cur_sc;
        logic [7:0] wpc, eopc, eimm;
        logic       etwo;
        logic [25:0] snap, cur;
        int idle;

        // sc, st, fl, tg, ca, addr, en, imm | valid, pc, opc, imm, two
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 1, 8'h00, 8'h10, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h02, 1, 0, 1, 8'h01, 8'h20, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h03, 1, 0, 1, 8'h02, 8'h30, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h04, 1, 0, 1, 8'h03, 8'h40, 8'h00, 0));
        vecs.push_back(mk(4, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(4, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(4, 0, 0, 8'h00, 1, 8'h02, 1, 1, 1, 8'h00, 8'hC5, 8'h7E, 1));
        vecs.push_back(mk(4, 0, 0, 8'h00, 1, 8'h03, 1, 0, 1, 8'h02, 8'h11, 8'h00, 0));
        vecs.push_back(mk(4, 0, 0, 8'h00, 1, 8'h04, 1, 0, 1, 8'h03, 8'h22, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h01, 1, 0, 1, 8'h00, 8'h10, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h02, 0, 0, 0, 8'h00, 8'h10, 8'h00, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 0, 0, 0, 8'h00, 8'h10, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h03, 1, 1, 1, 8'h01, 8'hC5, 8'h7E, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 8'h04, 1, 0, 1, 8'h03, 8'h11, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h01, 1, 0, 1, 8'h00, 8'h10, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h02, 1, 0, 1, 8'h01, 8'h20, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h03, 1, 0, 1, 8'h02, 8'h30, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h04, 1, 0, 1, 8'h03, 8'h40, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h05, 0, 0, 0, 8'h03, 8'h40, 8'h00, 0));
        vecs.push_back(mk(2, 1, 1, 8'h40, 0, 8'h00, 1, 0, 0, 8'h03, 8'h40, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h40, 0, 0, 0, 8'h03, 8'h40, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h41, 1, 0, 1, 8'h40, 8'h55, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 8'h00, 1, 8'h42, 1, 0, 1, 8'h41, 8'h00, 8'h00, 0));
        vecs.push_back(mk(3, 0, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(3, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(3, 0, 0, 8'h00, 1, 8'h01, 1, 1, 1, 8'hFF, 8'hC0, 8'hAA, 1));
        vecs.push_back(mk(3, 0, 0, 8'h00, 1, 8'h02, 1, 0, 1, 8'h01, 8'h33, 8'h00, 0));

        cur_sc = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].sc != cur_sc) begin
                cur_sc = vecs[i].sc;
                load_scen(cur_sc);
            end
            stall = vecs[i].st; flush = vecs[i].fl; target = vecs[i].tg;
            #1;
            if (vecs[i].ca) chk($sformatf("v%0d_addr", i), {24'b0, addr}, {24'b0, vecs[i].ad});
            chk($sformatf("v%0d_pcctl", i), {30'b0, pc_en, pc_imm}, {30'b0, vecs[i].en, vecs[i].im});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ifid", i), {6'b0, v, ipc, iopc, iimm, two},
                {6'b0, vecs[i].ev, vecs[i].ep, vecs[i].eo, vecs[i].ei, vecs[i].et});
            @(negedge clk);
        end

        // Async reset in the middle of a 2-byte fetch.
        load_scen(1);
        stall = 1'b0; flush = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("pre_rst_valid", {31'b0, v}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_ifid", {6'b0, v, ipc, iopc, iimm, two}, 32'h0);
        chk("arst_pc_en", {31'b0, pc_en}, 32'h0);
        chk("arst_addr", {24'b0, addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_c0_valid", {31'b0, v}, 32'h0);
        @(posedge clk); #1;
        chk("arst_c1_ifid", {6'b0, v, ipc, iopc, iimm, two}, {6'b0, 1'b1, 8'h00, 8'h10, 8'h00, 1'b0});
        @(posedge clk); #1;
        chk("arst_c2_bubble", {31'b0, v}, 32'h0);

        // Random program with random stalls and branches, scored by a program walk.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 2) == 0) ? {4'hC, 4'($urandom)} : 8'($urandom);
        reset_pc = 8'($urandom);
        do_reset(1'b0);
        wpc  = reset_pc;
        snap = '0;
        idle = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 19) == 0);
            target = 8'($urandom);
            @(posedge clk);
            #1;
            cur = {v, ipc, iopc, iimm, two};
            if (flush) begin
                chk("rnd_flush_valid", {31'b0, v}, 32'h0);
                wpc  = target;
                idle = 0;
            end else if (stall) begin
                chk("rnd_stall_hold", {6'b0, cur}, {6'b0, snap});
            end else if (v) begin
                eopc = mem[wpc];
                etwo = is_two(eopc);
                eimm = etwo ? mem[8'(wpc + 8'd1)] : 8'h00;
                chk("rnd_issue", {6'b0, cur}, {6'b0, 1'b1, wpc, eopc, eimm, etwo});
                wpc  = wpc + (etwo ? 8'd2 : 8'd1);
                idle = 0;
            end else begin
                idle++;
                if (idle > 2) begin
                    chk("rnd_progress", idle, 2);
                    idle = 0;
                end
            end
            snap = cur;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
